// File: rtl/idma_legalizer_r_axi_w_obi_buf_if.sv
// Bundles the request, read-burst, write-word and control signals of the
// AXI-read / OBI-write legalizer. The slave view belongs to the legalizer; the
// master view belongs to whatever drives requests and consumes the bursts.
interface idma_legalizer_r_axi_w_obi_buf_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 32
);
  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);

  // 1D request input
  logic [AddrWidth-1:0]   req_src_addr_i;
  logic [AddrWidth-1:0]   req_dst_addr_i;
  logic [LenWidth-1:0]    req_length_i;
  logic                   req_last_i;
  logic                   req_valid_i;
  logic                   req_ready_o;

  // AXI read burst output
  logic [AddrWidth-1:0]   r_addr_o;
  logic [7:0]             r_len_o;
  logic [OffsetWidth-1:0] r_offset_o;
  logic [OffsetWidth-1:0] r_tailer_o;
  logic [OffsetWidth-1:0] r_shift_o;
  logic                   r_is_single_o;
  logic                   r_valid_o;
  logic                   r_ready_i;

  // OBI write word output
  logic [AddrWidth-1:0]   w_addr_o;
  logic [StrbWidth-1:0]   w_be_o;
  logic [OffsetWidth-1:0] w_offset_o;
  logic [OffsetWidth-1:0] w_tailer_o;
  logic [OffsetWidth-1:0] w_shift_o;
  logic                   w_last_o;
  logic                   w_super_last_o;
  logic                   w_valid_o;
  logic                   w_ready_i;

  // Control and status
  logic                   flush_i;
  logic                   kill_i;
  logic                   r_busy_o;
  logic                   w_busy_o;

  modport slave (
    input  req_src_addr_i, req_dst_addr_i, req_length_i, req_last_i, req_valid_i,
    output req_ready_o,
    output r_addr_o, r_len_o, r_offset_o, r_tailer_o, r_shift_o, r_is_single_o, r_valid_o,
    input  r_ready_i,
    output w_addr_o, w_be_o, w_offset_o, w_tailer_o, w_shift_o, w_last_o, w_super_last_o,
    output w_valid_o,
    input  w_ready_i,
    input  flush_i, kill_i,
    output r_busy_o, w_busy_o
  );

  modport master (
    output req_src_addr_i, req_dst_addr_i, req_length_i, req_last_i, req_valid_i,
    input  req_ready_o,
    input  r_addr_o, r_len_o, r_offset_o, r_tailer_o, r_shift_o, r_is_single_o, r_valid_o,
    output r_ready_i,
    input  w_addr_o, w_be_o, w_offset_o, w_tailer_o, w_shift_o, w_last_o, w_super_last_o,
    input  w_valid_o,
    output w_ready_i,
    output flush_i, kill_i,
    input  r_busy_o, w_busy_o
  );
endinterface

// File: rtl/idma_legalizer_r_axi_w_obi_buf.sv
// Legalizer for AXI-read / OBI-write transfers. Buffers 1D requests in a small
// FIFO, then splits each one into AXI INCR read bursts that never cross a burst
// window and into single-word OBI writes with generated byte enables. The read
// and write machines load together but then run independently.
module idma_legalizer_r_axi_w_obi_buf #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned LenWidth     = 32,
  parameter int unsigned PageSize     = 4096,
  parameter int unsigned MaxBeats     = 256,
  parameter int unsigned ReqFifoDepth = 2
) (
  input logic                             clk_i,
  input logic                             rst_ni,
  idma_legalizer_r_axi_w_obi_buf_if.slave bus
);

  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned OffsetWidth = $clog2(StrbWidth);
  localparam int unsigned BeatBytes   = MaxBeats * StrbWidth;
  localparam int unsigned BurstBytes  = (PageSize < BeatBytes) ? PageSize : BeatBytes;
  localparam int unsigned BurstBits   = $clog2(BurstBytes);
  localparam int unsigned PtrWidth    = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned CntWidth    = $clog2(ReqFifoDepth + 1);

  typedef struct packed {
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [LenWidth-1:0]  length;
    logic                 last;
  } req_t;

  // ---------------------------------------------------------------------------
  // Request FIFO (registered output, no fall-through)
  // ---------------------------------------------------------------------------
  req_t                fifo_mem_q [ReqFifoDepth];
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                load;
  req_t                req_in;
  req_t                fifo_head;

  assign fifo_full  = (count_q == CntWidth'(ReqFifoDepth));
  assign fifo_empty = (count_q == '0);
  assign req_in     = '{src:    bus.req_src_addr_i,
                        dst:    bus.req_dst_addr_i,
                        length: bus.req_length_i,
                        last:   bus.req_last_i};
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  assign bus.req_ready_o = !fifo_full && !bus.kill_i;
  assign push            = bus.req_valid_i && bus.req_ready_o;

  // Entry storage; a slot is only read after it was written, so no reset needed
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= req_in;
    end
  end

  // Pointer and occupancy bookkeeping; kill drops every buffered request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.kill_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrWidth'(ReqFifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_q <= (rd_ptr_q == PtrWidth'(ReqFifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, load})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read machine state and burst sizing
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0]   r_addr_q;
  logic [LenWidth-1:0]    r_rem_q;
  logic                   r_active_q;
  logic [OffsetWidth-1:0] r_shift_q;
  logic [OffsetWidth-1:0] r_off;
  logic [LenWidth-1:0]    r_page_room;
  logic [LenWidth-1:0]    r_chunk;
  logic [LenWidth-1:0]    r_span;
  logic                   r_final;
  logic                   r_valid;
  logic                   r_hs;
  logic                   r_free;

  // Burst size is bounded by what is left and by the distance to the window end
  always_comb begin
    r_off       = r_addr_q[OffsetWidth-1:0];
    r_page_room = LenWidth'(BurstBytes) - LenWidth'(r_addr_q[BurstBits-1:0]);
    r_chunk     = (r_rem_q < r_page_room) ? r_rem_q : r_page_room;
    r_span      = r_chunk + LenWidth'(r_off);
    r_final     = (r_rem_q == r_chunk);
  end

  assign r_valid = r_active_q && !bus.flush_i && !bus.kill_i;
  assign r_hs    = r_valid && bus.r_ready_i;
  assign r_free  = !r_active_q || (r_hs && r_final);

  // ---------------------------------------------------------------------------
  // Write machine state and word sizing
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0]   w_addr_q;
  logic [LenWidth-1:0]    w_rem_q;
  logic                   w_active_q;
  logic                   w_super_q;
  logic [OffsetWidth-1:0] w_shift_q;
  logic [OffsetWidth-1:0] w_off;
  logic [LenWidth-1:0]    w_room;
  logic [LenWidth-1:0]    w_chunk;
  logic [StrbWidth-1:0]   w_be;
  logic                   w_last;
  logic                   w_valid;
  logic                   w_hs;
  logic                   w_free;

  // One word per access; a zero-length request yields a single empty last word
  always_comb begin
    w_off   = w_addr_q[OffsetWidth-1:0];
    w_room  = LenWidth'(StrbWidth) - LenWidth'(w_off);
    w_chunk = (w_rem_q < w_room) ? w_rem_q : w_room;
    w_last  = (w_rem_q == w_chunk);
    w_be    = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      if ((LenWidth'(i) >= LenWidth'(w_off)) &&
          (LenWidth'(i) < (LenWidth'(w_off) + w_chunk))) begin
        w_be[i] = 1'b1;
      end
    end
  end

  assign w_valid = w_active_q && !bus.flush_i && !bus.kill_i;
  assign w_hs    = w_valid && bus.w_ready_i;
  assign w_free  = !w_active_q || (w_hs && w_last);

  // Both machines take the head request once each is idle or finishing now
  assign load = !fifo_empty && !bus.flush_i && !bus.kill_i && r_free && w_free;

  // Read machine: load, then advance by one burst per handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr_q   <= '0;
      r_rem_q    <= '0;
      r_active_q <= 1'b0;
      r_shift_q  <= '0;
    end else if (bus.kill_i) begin
      r_addr_q   <= '0;
      r_rem_q    <= '0;
      r_active_q <= 1'b0;
      r_shift_q  <= '0;
    end else if (load) begin
      r_addr_q   <= fifo_head.src;
      r_rem_q    <= fifo_head.length;
      r_active_q <= (fifo_head.length != '0);
      r_shift_q  <= fifo_head.src[OffsetWidth-1:0];
    end else if (r_hs) begin
      r_addr_q   <= r_addr_q + AddrWidth'(r_chunk);
      r_rem_q    <= r_rem_q - r_chunk;
      r_active_q <= !r_final;
    end
  end

  // Write machine: load, then advance by one word per handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_addr_q   <= '0;
      w_rem_q    <= '0;
      w_active_q <= 1'b0;
      w_super_q  <= 1'b0;
      w_shift_q  <= '0;
    end else if (bus.kill_i) begin
      w_addr_q   <= '0;
      w_rem_q    <= '0;
      w_active_q <= 1'b0;
      w_super_q  <= 1'b0;
      w_shift_q  <= '0;
    end else if (load) begin
      w_addr_q   <= fifo_head.dst;
      w_rem_q    <= fifo_head.length;
      w_active_q <= 1'b1;
      w_super_q  <= fifo_head.last;
      w_shift_q  <= -fifo_head.dst[OffsetWidth-1:0];
    end else if (w_hs) begin
      w_addr_q   <= w_addr_q + AddrWidth'(w_chunk);
      w_rem_q    <= w_rem_q - w_chunk;
      w_active_q <= !w_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; data fields read as zero while a machine is idle
  // ---------------------------------------------------------------------------
  assign bus.r_valid_o     = r_valid;
  assign bus.r_busy_o      = r_active_q;
  assign bus.r_addr_o      = r_active_q ? {r_addr_q[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}} : '0;
  assign bus.r_len_o       = r_active_q ? 8'((r_span - LenWidth'(1)) >> OffsetWidth) : '0;
  assign bus.r_offset_o    = r_active_q ? r_off : '0;
  assign bus.r_tailer_o    = r_active_q ? r_span[OffsetWidth-1:0] : '0;
  assign bus.r_shift_o     = r_active_q ? r_shift_q : '0;
  assign bus.r_is_single_o = r_active_q && (r_span <= LenWidth'(StrbWidth));

  assign bus.w_valid_o      = w_valid;
  assign bus.w_busy_o       = w_active_q;
  assign bus.w_addr_o       = w_active_q ? {w_addr_q[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}} : '0;
  assign bus.w_be_o         = w_active_q ? w_be : '0;
  assign bus.w_offset_o     = w_active_q ? w_off : '0;
  assign bus.w_tailer_o     = w_active_q ? (w_off + w_chunk[OffsetWidth-1:0]) : '0;
  assign bus.w_shift_o      = w_active_q ? w_shift_q : '0;
  assign bus.w_last_o       = w_active_q && w_last;
  assign bus.w_super_last_o = w_active_q && w_last && w_super_q;

endmodule

// File: tb/tb_idma_legalizer_r_axi_w_obi_buf.sv
// Directed bench for the AXI-read / OBI-write legalizer (32-bit bus, 1 KiB
// burst window, two-entry request FIFO). Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_idma_legalizer_r_axi_w_obi_buf;

  logic clk_i;
  logic rst_ni;
  int   errors = 0;
  int   checks = 0;

  idma_legalizer_r_axi_w_obi_buf_if #(
    .DataWidth(32), .AddrWidth(32), .LenWidth(32)
  ) bus ();

  idma_legalizer_r_axi_w_obi_buf #(
    .DataWidth(32), .AddrWidth(32), .LenWidth(32),
    .PageSize(4096), .MaxBeats(256), .ReqFifoDepth(2)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  // Free-running 100 MHz clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Watchdog so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic valid, input logic [31:0] src,
                               input logic [31:0] dst, input logic [31:0] len,
                               input logic last);
    bus.req_valid_i    = valid;
    bus.req_src_addr_i = src;
    bus.req_dst_addr_i = dst;
    bus.req_length_i   = len;
    bus.req_last_i     = last;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkRead(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] off, input logic [1:0] tail, input logic single);
    checkOutput({tag, " r_valid"},  bus.r_valid_o,     1);
    checkOutput({tag, " r_addr"},   bus.r_addr_o,      addr);
    checkOutput({tag, " r_len"},    bus.r_len_o,       len);
    checkOutput({tag, " r_offset"}, bus.r_offset_o,    off);
    checkOutput({tag, " r_tailer"}, bus.r_tailer_o,    tail);
    checkOutput({tag, " r_single"}, bus.r_is_single_o, single);
  endtask

  task automatic checkWrite(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic last, input logic super_last);
    checkOutput({tag, " w_valid"},      bus.w_valid_o,      1);
    checkOutput({tag, " w_addr"},       bus.w_addr_o,       addr);
    checkOutput({tag, " w_be"},         bus.w_be_o,         be);
    checkOutput({tag, " w_last"},       bus.w_last_o,       last);
    checkOutput({tag, " w_super_last"}, bus.w_super_last_o, super_last);
  endtask

  task automatic nextCycle();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni        = 1'b0;
    bus.r_ready_i = 1'b0;
    bus.w_ready_i = 1'b0;
    bus.flush_i   = 1'b0;
    bus.kill_i    = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    // Reset state
    #2;
    checkOutput("rst r_valid", bus.r_valid_o, 0);
    checkOutput("rst w_valid", bus.w_valid_o, 0);
    checkOutput("rst r_busy",  bus.r_busy_o,  0);
    checkOutput("rst w_busy",  bus.w_busy_o,  0);
    checkOutput("rst r_addr",  bus.r_addr_o,  0);
    checkOutput("rst r_len",   bus.r_len_o,   0);
    checkOutput("rst w_addr",  bus.w_addr_o,  0);
    checkOutput("rst w_be",    bus.w_be_o,    0);
    checkOutput("rst w_last",  bus.w_last_o,  0);
    nextCycle(); rst_ni = 1'b1; #1;
    checkOutput("rst req_ready", bus.req_ready_o, 1);

    // Unaligned page cross
    $display("[TB] unaligned page cross");
    bus.r_ready_i = 1'b1; bus.w_ready_i = 1'b1;
    nextCycle(); applyStimulus(1, 32'h0FFE, 32'h1001, 8, 1); #1;
    checkOutput("t1 req_ready", bus.req_ready_o, 1);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0); #1;
    checkOutput("t1 c1 r_valid", bus.r_valid_o, 0);
    checkOutput("t1 c1 w_valid", bus.w_valid_o, 0);
    nextCycle(); #1;
    checkRead("t1 rd0", 32'h0FFC, 0, 2, 0, 1);
    checkOutput("t1 r_shift", bus.r_shift_o, 2);
    checkOutput("t1 w_shift", bus.w_shift_o, 3);
    checkWrite("t1 wr0", 32'h1000, 4'hE, 0, 0);
    nextCycle(); #1;
    checkRead("t1 rd1", 32'h1000, 1, 0, 2, 0);
    checkWrite("t1 wr1", 32'h1004, 4'hF, 0, 0);
    nextCycle(); #1;
    checkOutput("t1 r_valid done", bus.r_valid_o, 0);
    checkOutput("t1 r_busy done",  bus.r_busy_o,  0);
    checkWrite("t1 wr2", 32'h1008, 4'h1, 1, 1);
    nextCycle(); #1;
    checkOutput("t1 w_valid done", bus.w_valid_o, 0);
    checkOutput("t1 w_busy done",  bus.w_busy_o,  0);

    // Max burst split
    $display("[TB] max burst split");
    nextCycle(); applyStimulus(1, 32'h0, 32'h8000, 2048, 0); #1;
    nextCycle(); applyStimulus(0, 0, 0, 0, 0); #1;
    nextCycle(); #1;
    checkRead("t2 rd0", 32'h0, 255, 0, 0, 0);
    checkOutput("t2 w_be first", bus.w_be_o, 4'hF);
    for (int i = 0; i < 512; i++) begin
      if (i > 0) begin
        nextCycle(); #1;
      end
      if (i == 1) checkRead("t2 rd1", 32'h400, 255, 0, 0, 0);
      if (i == 2) checkOutput("t2 r_valid end", bus.r_valid_o, 0);
      checkOutput("t2 w_valid", bus.w_valid_o, 1);
      checkOutput("t2 w_addr",  bus.w_addr_o, 32'h8000 + 32'(4 * i));
      checkOutput("t2 w_last",  bus.w_last_o, (i == 511) ? 1 : 0);
    end
    nextCycle(); #1;
    checkOutput("t2 w_valid done", bus.w_valid_o, 0);
    checkOutput("t2 w_busy done",  bus.w_busy_o,  0);

    // Zero length
    $display("[TB] zero length");
    nextCycle(); applyStimulus(1, 32'h40, 32'h20, 0, 1); #1;
    nextCycle(); applyStimulus(0, 0, 0, 0, 0); #1;
    nextCycle(); #1;
    checkOutput("t3 r_valid", bus.r_valid_o, 0);
    checkOutput("t3 r_busy",  bus.r_busy_o,  0);
    checkWrite("t3 wr", 32'h20, 4'h0, 1, 1);
    nextCycle(); #1;
    checkOutput("t3 w_valid done", bus.w_valid_o, 0);
    checkOutput("t3 r_valid done", bus.r_valid_o, 0);

    // Buffering with the write side stalled
    $display("[TB] buffering");
    bus.w_ready_i = 1'b0;
    nextCycle(); applyStimulus(1, 32'h100, 32'h200, 4, 0); #1;
    checkOutput("t4 ready A", bus.req_ready_o, 1);
    nextCycle(); applyStimulus(1, 32'h300, 32'h400, 4, 0); #1;
    checkOutput("t4 ready B", bus.req_ready_o, 1);
    nextCycle(); applyStimulus(1, 32'h500, 32'h600, 4, 0); #1;
    checkOutput("t4 ready C", bus.req_ready_o, 1);
    checkRead("t4 rdA", 32'h100, 0, 0, 0, 1);
    checkOutput("t4 stalled w_addr", bus.w_addr_o, 32'h200);
    nextCycle(); applyStimulus(1, 32'h700, 32'h800, 4, 0); #1;
    checkOutput("t4 ready D", bus.req_ready_o, 0);
    checkOutput("t4 stalled w_valid", bus.w_valid_o, 1);
    checkOutput("t4 r_valid idle", bus.r_valid_o, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0); bus.w_ready_i = 1'b1; #1;
    checkOutput("t4 still full", bus.req_ready_o, 0);
    checkWrite("t4 wrA", 32'h200, 4'hF, 1, 0);
    nextCycle(); #1;
    checkWrite("t4 wrB", 32'h400, 4'hF, 1, 0);
    checkRead("t4 rdB", 32'h300, 0, 0, 0, 1);
    checkOutput("t4 ready after pop", bus.req_ready_o, 1);
    nextCycle(); #1;
    checkWrite("t4 wrC", 32'h600, 4'hF, 1, 0);
    checkRead("t4 rdC", 32'h500, 0, 0, 0, 1);
    nextCycle(); #1;
    checkOutput("t4 w_valid done", bus.w_valid_o, 0);
    checkOutput("t4 w_busy done",  bus.w_busy_o,  0);
    nextCycle(); #1;
    checkOutput("t4 D not taken", bus.w_valid_o, 0);

    // Kill mid-transfer with one request queued
    $display("[TB] kill");
    bus.r_ready_i = 1'b0;
    nextCycle(); applyStimulus(1, 32'h1000, 32'h3000, 64, 0); #1;
    nextCycle(); applyStimulus(1, 32'h5000, 32'h6000, 8, 0); #1;
    nextCycle(); applyStimulus(0, 0, 0, 0, 0); #1;
    checkWrite("t5 wr0", 32'h3000, 4'hF, 0, 0);
    checkRead("t5 rd0", 32'h1000, 15, 0, 0, 0);
    nextCycle(); #1;
    checkOutput("t5 wr1 addr", bus.w_addr_o, 32'h3004);
    nextCycle(); bus.kill_i = 1'b1; applyStimulus(1, 32'h7000, 32'h7000, 4, 0); #1;
    checkOutput("t5 kill r_valid",   bus.r_valid_o,   0);
    checkOutput("t5 kill w_valid",   bus.w_valid_o,   0);
    checkOutput("t5 kill req_ready", bus.req_ready_o, 0);
    nextCycle(); bus.kill_i = 1'b0; applyStimulus(0, 0, 0, 0, 0); #1;
    checkOutput("t5 post r_busy",    bus.r_busy_o,    0);
    checkOutput("t5 post w_busy",    bus.w_busy_o,    0);
    checkOutput("t5 post r_valid",   bus.r_valid_o,   0);
    checkOutput("t5 post w_valid",   bus.w_valid_o,   0);
    checkOutput("t5 post req_ready", bus.req_ready_o, 1);
    nextCycle(); #1;
    checkOutput("t5 fifo empty w", bus.w_valid_o, 0);
    checkOutput("t5 fifo empty r", bus.r_valid_o, 0);
    nextCycle(); #1;
    checkOutput("t5 fifo empty w2", bus.w_valid_o, 0);

    // Flush holds state for five cycles
    $display("[TB] flush");
    nextCycle(); applyStimulus(1, 32'h2000, 32'h4000, 64, 0); #1;
    nextCycle(); applyStimulus(0, 0, 0, 0, 0); #1;
    nextCycle(); #1;
    checkWrite("t6 wr0", 32'h4000, 4'hF, 0, 0);
    checkRead("t6 rd0", 32'h2000, 15, 0, 0, 0);
    nextCycle(); #1;
    checkOutput("t6 wr1 addr", bus.w_addr_o, 32'h4004);
    for (int i = 0; i < 5; i++) begin
      nextCycle(); bus.flush_i = 1'b1; #1;
      checkOutput("t6 flush r_valid", bus.r_valid_o, 0);
      checkOutput("t6 flush w_valid", bus.w_valid_o, 0);
      checkOutput("t6 flush r_busy",  bus.r_busy_o,  1);
      checkOutput("t6 flush w_busy",  bus.w_busy_o,  1);
    end
    nextCycle(); bus.flush_i = 1'b0; #1;
    checkWrite("t6 resume wr", 32'h4008, 4'hF, 0, 0);
    checkRead("t6 resume rd", 32'h2000, 15, 0, 0, 0);
    nextCycle(); bus.kill_i = 1'b1; #1;
    nextCycle(); bus.kill_i = 1'b0; #1;
    checkOutput("t6 cleanup w_busy", bus.w_busy_o, 0);

    // Asynchronous reset in the middle of a transfer
    $display("[TB] async reset");
    nextCycle(); applyStimulus(1, 32'h0, 32'h0, 64, 0); #1;
    nextCycle(); applyStimulus(0, 0, 0, 0, 0); #1;
    nextCycle(); #1;
    checkOutput("t7 w_busy before", bus.w_busy_o, 1);
    nextCycle(); #1; rst_ni = 1'b0; #1;
    checkOutput("t7 r_busy async", bus.r_busy_o,  0);
    checkOutput("t7 w_busy async", bus.w_busy_o,  0);
    checkOutput("t7 w_valid async", bus.w_valid_o, 0);
    nextCycle(); rst_ni = 1'b1; #1;
    checkOutput("t7 req_ready", bus.req_ready_o, 1);
    nextCycle(); #1;
    checkOutput("t7 idle after", bus.w_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
